// File: rtl/shift_add_mult_pkg.sv
// rtl/shift_add_mult_pkg.sv - shared types and defaults for the shift-add multiplier
// Contents:
//   DEFAULT_WIDTH : default operand width in bits
//   state_e       : IDLE / RUN / DONE controller states
package shift_add_mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential shift-and-add multiplier, fixed WIDTH-cycle iteration
// Configuration macro: SHIFT_ADD_MULT_SIGNED_EN (defined = two's complement operands,
//                      undefined = unsigned only)
// Ports:
//   clk_in  in   clock, rising edge
//   rst_in  in   synchronous active-high reset
//   start   in   begin a multiply (sampled only while ready=1)
//   x       in   WIDTH-bit multiplicand
//   y       in   WIDTH-bit multiplier
//   product out  2*WIDTH-bit result, held from done until the next accepted start completes
//   ready   out  high in IDLE
//   done    out  one-cycle pulse, product valid
module shift_add_multiplier
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ready,
  output logic                 done
);

  localparam logic [WIDTH-1:0] LAST_ITER = WIDTH'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH-1:0]     mag_x, mag_y;
  logic [2*WIDTH-1:0]   result;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  logic neg_q, neg_d;

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is still
  // exact when read back as an unsigned WIDTH-bit number.
  always_comb begin
    mag_x = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    mag_y = y[WIDTH-1] ? (~y + WIDTH'(1)) : y;
    neg_d = neg_q;
    if (state_q == IDLE && start) begin
      neg_d = x[WIDTH-1] ^ y[WIDTH-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end

  assign result = neg_q ? (~acc_d + (2*WIDTH)'(1)) : acc_d;
`else
  always_comb begin
    mag_x = x;
    mag_y = y;
  end

  assign result = acc_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, mag_x};
          mplier_d = mag_y;
          acc_d    = '0;
        end
      end
      RUN: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + WIDTH'(1);
        if (cnt_q == LAST_ITER) begin
          // Final add is folded into the result on the same edge that enters DONE.
          state_d   = DONE;
          product_d = result;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;
  assign ready   = (state_q == IDLE);
  assign done    = (state_q == DONE);

endmodule
